// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage; owns the PC, drives the instruction ROM address, and fills the IF/ID register
// Ports: clk/reset (async, active-high); stall, branch_taken, branch_target from hazard/branch logic;
// imem_addr/imem_instr to the combinational ROM; ifid_pc/ifid_instr/ifid_valid IF/ID register;
// fetch_fault sticky halt flag; fetch_count counts valid IF/ID loads.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC     = 64'd0,
    parameter int          IMEM_SIZE    = 1024,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);
    typedef enum logic {FETCH, HALT} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [64:0] last_byte;
    logic        bad_pc;
    // 65-bit sum so a PC near 2^64 cannot wrap past the bound check
    assign last_byte = {1'b0, pc_q} + 65'd3;
    assign bad_pc    = (pc_q[1:0] != 2'b00) || (last_byte >= 65'(IMEM_SIZE));
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        if (state_q == HALT || bad_pc || branch_taken) begin
            // bubble keeps the current PC for debug visibility
            ifid_pc_d    = pc_q;
            ifid_instr_d = BUBBLE_INSTR;
            ifid_valid_d = 1'b0;
            if (state_q == FETCH) begin
                if (bad_pc) state_d = HALT;
                else        pc_d    = branch_target;
            end
        end else if (!stall) begin
            pc_d          = pc_q + 64'd4;
            ifid_pc_d     = pc_q;
            ifid_instr_d  = imem_instr;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 64'd0;
            ifid_instr_q  <= BUBBLE_INSTR;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end
    assign imem_addr   = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_fault = (state_q == HALT);
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector bench for instruction_fetch
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    int          n_vec = 0;
    int          n_bad = 0;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // ROM word k holds k+1
    assign imem_instr = 32'(imem_addr >> 2) + 32'd1;

    typedef struct {
        logic        st;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt[9];

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                             input logic [31:0] instr, input logic valid, input logic fault,
                             input logic [31:0] cnt);
        cmp({tag, ".imem_addr"}, imem_addr, addr);
        cmp({tag, ".ifid_pc"}, ifid_pc, pc);
        cmp({tag, ".ifid_instr"}, 64'(ifid_instr), 64'(instr));
        cmp({tag, ".ifid_valid"}, 64'(ifid_valid), 64'(valid));
        cmp({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(fault));
        cmp({tag, ".fetch_count"}, 64'(fetch_count), 64'(cnt));
    endtask

    task automatic step(input logic st, input logic br, input logic [63:0] tgt);
        stall = st;
        branch_taken = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 64'd0,    64'd4,    64'd0,    32'd1,  1'b1, 1'b0, 32'd1};
        vt[1] = '{1'b0, 1'b0, 64'd0,    64'd8,    64'd4,    32'd2,  1'b1, 1'b0, 32'd2};
        vt[2] = '{1'b1, 1'b0, 64'd0,    64'd8,    64'd4,    32'd2,  1'b1, 1'b0, 32'd2};
        vt[3] = '{1'b1, 1'b0, 64'd0,    64'd8,    64'd4,    32'd2,  1'b1, 1'b0, 32'd2};
        vt[4] = '{1'b0, 1'b0, 64'd0,    64'd12,   64'd8,    32'd3,  1'b1, 1'b0, 32'd3};
        vt[5] = '{1'b1, 1'b1, 64'd64,   64'd64,   64'd12,   32'd0,  1'b0, 1'b0, 32'd3};
        vt[6] = '{1'b0, 1'b0, 64'd0,    64'd68,   64'd64,   32'd17, 1'b1, 1'b0, 32'd4};
        vt[7] = '{1'b0, 1'b1, 64'd1022, 64'd1022, 64'd68,   32'd0,  1'b0, 1'b0, 32'd4};
        vt[8] = '{1'b0, 1'b0, 64'd0,    64'd1022, 64'd1022, 32'd0,  1'b0, 1'b1, 32'd4};
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 64'd0;
        #12 reset = 1'b0;
        #1 check_all("reset", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            step(vt[i].st, vt[i].br, vt[i].tgt);
            check_all($sformatf("vec%0d", i), vt[i].addr, vt[i].pc, vt[i].instr,
                      vt[i].valid, vt[i].fault, vt[i].cnt);
        end
        // halted: nothing, not even a redirect, moves the stage
        for (int i = 0; i < 10; i++) begin
            step(1'(i % 3 == 2), 1'(i % 2), 64'd0);
            check_all($sformatf("halt%0d", i), 64'd1022, 64'd1022, 32'd0, 1'b0, 1'b1, 32'd4);
        end
        // async reset while halted, then run to pc 40 and reset mid-cycle
        #2 reset = 1'b1;
        #1 check_all("rst_halt", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'd0);
        check_all("pc40", 64'd40, 64'd36, 32'd10, 1'b1, 1'b0, 32'd10);
        #2 reset = 1'b1;
        #1 check_all("rst_async", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        #1 reset = 1'b0;
        step(1'b0, 1'b0, 64'd0);
        check_all("resume", 64'd4, 64'd0, 32'd1, 1'b1, 1'b0, 32'd1);
        // sequential run to the top of the ROM
        for (int i = 1; i < 255; i++) step(1'b0, 1'b0, 64'd0);
        check_all("pc1020", 64'd1020, 64'd1016, 32'd255, 1'b1, 1'b0, 32'd255);
        step(1'b0, 1'b0, 64'd0);
        check_all("last_word", 64'd1024, 64'd1020, 32'd256, 1'b1, 1'b0, 32'd256);
        step(1'b0, 1'b0, 64'd0);
        check_all("oob_fault", 64'd1024, 64'd1024, 32'd0, 1'b0, 1'b1, 32'd256);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0);
        check_all("oob_hold", 64'd1024, 64'd1024, 32'd0, 1'b0, 1'b1, 32'd256);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the 5-stage 64-bit ARM pipeline.
- Owns the program counter and drives the byte address of the combinational instruction ROM.
- Captures the returned 32-bit word into the IF/ID pipeline register together with its PC.
- Supports stall, branch redirect (with IF/ID flush), and detection of out-of-range or misaligned fetches.

Parameters:
- RESET_PC, 64'd0: PC value loaded on reset.
- IMEM_SIZE, 1024: instruction ROM size in bytes; power of two, greater than 4.
- BUBBLE_INSTR, 32'h0000_0000: instruction word placed in IF/ID when it holds a bubble.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit request to hold PC and IF/ID (load-use).
- branch_taken  input  1  redirect request from the branch-resolve stage.
- branch_target  input  64  byte address to redirect to.
- imem_addr  output  64  byte address to the instruction ROM; equals the PC register.
- imem_instr  input  32  combinational ROM read data for imem_addr.
- ifid_pc  output  64  PC of the instruction held in IF/ID.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_fault  output  1  sticky flag: fetch halted on a bad PC.
- fetch_count  output  32  number of valid instructions loaded into IF/ID since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC, ifid_pc = 0, ifid_instr = BUBBLE_INSTR, ifid_valid = 0, fetch_fault = 0, fetch_count = 0.
- imem_addr is the PC register directly (no combinational logic); the ROM returns data in the same cycle.
- Bad PC is defined as pc[1:0] != 0 OR pc + 3 >= IMEM_SIZE, with the sum computed in 64 bits without wrap.
- Per-posedge priority, first match wins:
  1. fetch_fault = 1: PC holds, IF/ID loads a bubble, count holds. This is the halted state; it is left only by reset.
  2. bad PC: fetch_fault <= 1, IF/ID loads a bubble, PC holds.
  3. branch_taken: pc <= branch_target, IF/ID loads a bubble (flushes the wrong-path fetch). branch_taken overrides a simultaneous stall.
  4. stall: PC, IF/ID and fetch_count all hold their values.
  5. normal: pc <= pc + 4, ifid_pc <= pc, ifid_instr <= imem_instr, ifid_valid <= 1, fetch_count <= fetch_count + 1.
- A bubble means ifid_valid = 0, ifid_instr = BUBBLE_INSTR and ifid_pc = pc (the current PC, kept for debug).
- State machine: FETCH (cases 2–5) and HALT (case 1, fetch_fault = 1).
  - FETCH -> HALT on a bad PC.
  - HALT -> FETCH only via reset.
- A misaligned or out-of-range branch_target is accepted into the PC. The fault is raised on the following edge, per case 2.
- pc + 4 wraps modulo 2^64 in arithmetic. In practice the bound check faults first.
- fetch_count wraps modulo 2^32.
- Latency: the instruction at PC p appears in IF/ID one cycle after imem_addr = p, unless a stall or redirect intervenes.
- Branch penalty is one bubble, produced by this stage. Flushing any deeper stages is outside this block.

Test Plan:
- Reset then run with no stall or branch, with ROM word k = k+1:
  - imem_addr sequence is 0, 4, 8, 12.
  - IF/ID shows (pc 0, instr 1), (4, 2), (8, 3) on consecutive cycles.
  - fetch_count = 3 after three edges.
- stall held high for 2 cycles at pc = 8:
  - imem_addr stays 8.
  - ifid_pc stays 4 and ifid_valid stays 1.
  - fetch_count is unchanged.
  - After release, IF/ID shows (8, 3).
- branch_taken = 1 and stall = 1 together at pc = 12 with branch_target = 64:
  - Next cycle imem_addr = 64 and ifid_valid = 0.
  - The cycle after, IF/ID shows (64, 17).
- branch_target = 1022 (misaligned):
  - PC loads 1022, then fetch_fault = 1 on the next edge.
  - PC stays 1022 and ifid_valid stays 0 for 10 cycles.
  - fetch_count is frozen.
- Sequential run to pc = 1020:
  - The word at 1020 is fetched normally.
  - At pc = 1024 fetch_fault = 1 and no further valid instructions are loaded.
- Assert reset asynchronously between clock edges while ifid_valid = 1 and pc = 40:
  - All outputs go to their reset values immediately, with no clock edge.
  - Normal fetch from 0 resumes after reset deasserts.
